// File: rtl/i2c_tx_ctrl_pkg.sv
// i2c_pkg: shared definitions for the I2C byte-transmit controller.
//   state_t      - controller FSM states
//   Q0..Q3       - quarter-phase indices within one SCL period
//   CLK_DIV_DEF  - default clk cycles per SCL quarter-period
//   bit_rev8     - byte bit reversal (the data shift unit shifts LSB first)
package i2c_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BIT,
    S_ACK,
    S_STOP
  } state_t;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam int CLK_DIV_DEF = 4;

  function automatic logic [7:0] bit_rev8(input logic [7:0] d);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = d[7-i];
    return r;
  endfunction

endpackage

// File: rtl/i2c_tx_ctrl_if.sv
// i2c_tx_ctrl_if: request/line bundle of the I2C byte-transmit controller.
//   req, din, sda_in       - transfer request, byte, sampled SDA level
//   go, data, dbit         - load strobe, reversed byte, shift strobe to data unit
//   sda_sel, sda_ctl, scl  - SDA source select, controller SDA level, SCL level
//   busy, done, ack_err    - status
// Modport slave is taken by the controller, master by whatever drives it.
interface i2c_tx_ctrl_if;
  logic       req;
  logic [7:0] din;
  logic       sda_in;
  logic       go;
  logic [7:0] data;
  logic       dbit;
  logic       sda_sel;
  logic       sda_ctl;
  logic       scl;
  logic       busy;
  logic       done;
  logic       ack_err;

  modport master (
    output req, din, sda_in,
    input  go, data, dbit, sda_sel, sda_ctl, scl, busy, done, ack_err
  );

  modport slave (
    input  req, din, sda_in,
    output go, data, dbit, sda_sel, sda_ctl, scl, busy, done, ack_err
  );
endinterface

// File: rtl/i2c_tx_ctrl_qtick.sv
// i2c_qtick: quarter-period timebase for the I2C controller.
//   clk, rst - clock, asynchronous active-high reset
//   clr      - restart at quarter 0, count 0 (transfer accepted)
//   en       - count while a transfer is in progress
//   qtick    - high on the last clk of each quarter
//   q        - current quarter index (0..3), wraps with the SCL period
module i2c_qtick
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  output logic       qtick,
  output logic [1:0] q
);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign qtick = en && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      q   <= Q0;
    end else if (clr) begin
      cnt <= '0;
      q   <= Q0;
    end else if (en) begin
      if (cnt == LAST) begin
        cnt <= '0;
        q   <= q + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/i2c_tx_ctrl.sv
// i2c_tx_ctrl: I2C single-byte transmit controller (START, 8 data bits,
// ACK sample, STOP). The byte itself is shifted onto SDA by an external
// data unit; this block loads it (go/data), paces it (dbit) and drives
// SCL plus the control level of SDA.
//   clk, rst - clock, asynchronous active-high reset
//   bus      - i2c_tx_ctrl_if.slave (req/din/sda_in in; go/data/dbit,
//              sda_sel/sda_ctl/scl, busy/done/ack_err out)
// Every output is a register. The next state and next quarter are
// resolved first and the outputs are decoded from them, so the registered
// outputs line up with the state they belong to.
module i2c_tx_ctrl
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input logic          clk,
  input logic          rst,
  i2c_tx_ctrl_if.slave bus
);
  state_t     state, state_nx;
  logic [2:0] bitcnt, bitcnt_nx;
  logic       first_q;
  logic       accept, qtick, qend, first_nx;
  logic [1:0] q, q_nx;
  logic       go_nx, dbit_nx, sel_nx, ctl_nx, scl_nx, busy_nx, done_nx, ack_err_nx;
  logic [7:0] data_nx;

  i2c_qtick #(.CLK_DIV(CLK_DIV)) u_qtick (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .en   (bus.busy),
    .qtick(qtick),
    .q    (q)
  );

  assign accept   = (state == S_IDLE) && bus.req;
  assign qend     = qtick && (q == Q3);
  // next clk opens a quarter: either a fresh transfer or a quarter rollover
  assign first_nx = accept || qtick;
  assign q_nx     = accept ? Q0 : (qtick ? q + 2'd1 : q);

  always_comb begin
    state_nx  = state;
    bitcnt_nx = bitcnt;
    unique case (state)
      S_IDLE:  if (bus.req) state_nx = S_START;
      S_START: if (qend) begin
        state_nx  = S_BIT;
        bitcnt_nx = 3'd0;
      end
      S_BIT:   if (qend) begin
        if (bitcnt == 3'd7) begin
          state_nx  = S_ACK;
          bitcnt_nx = 3'd0;
        end else begin
          bitcnt_nx = bitcnt + 3'd1;
        end
      end
      S_ACK:   if (qend) state_nx = S_STOP;
      S_STOP:  if (qend) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    scl_nx  = 1'b1;
    ctl_nx  = 1'b1;
    sel_nx  = 1'b0;
    busy_nx = 1'b1;
    go_nx   = 1'b0;
    dbit_nx = 1'b0;
    done_nx = 1'b0;
    unique case (state_nx)
      S_IDLE: begin
        busy_nx = 1'b0;
        done_nx = (state == S_STOP);
      end
      S_START: begin
        ctl_nx = 1'b0;
        scl_nx = (q_nx == Q0) || (q_nx == Q1);
        go_nx  = accept;
      end
      S_BIT: begin
        sel_nx  = 1'b1;
        ctl_nx  = 1'b0;
        scl_nx  = (q_nx == Q1) || (q_nx == Q2);
        dbit_nx = (q_nx == Q0) && first_nx;
      end
      S_ACK: begin
        scl_nx = (q_nx == Q1) || (q_nx == Q2);
      end
      S_STOP: begin
        // SCL rises first, SDA follows a quarter later: the STOP condition
        scl_nx = (q_nx != Q0);
        ctl_nx = (q_nx == Q2) || (q_nx == Q3);
      end
      default: ;
    endcase
  end

  always_comb begin
    data_nx    = accept ? bit_rev8(bus.din) : bus.data;
    ack_err_nx = bus.ack_err;
    if (accept) begin
      ack_err_nx = 1'b0;
    end else if ((state == S_ACK) && (q == Q2) && first_q) begin
      ack_err_nx = bus.sda_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      bitcnt      <= 3'd0;
      first_q     <= 1'b0;
      bus.go      <= 1'b0;
      bus.data    <= 8'd0;
      bus.dbit    <= 1'b0;
      bus.sda_sel <= 1'b0;
      bus.sda_ctl <= 1'b1;
      bus.scl     <= 1'b1;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.ack_err <= 1'b0;
    end else begin
      state       <= state_nx;
      bitcnt      <= bitcnt_nx;
      first_q     <= first_nx;
      bus.go      <= go_nx;
      bus.data    <= data_nx;
      bus.dbit    <= dbit_nx;
      bus.sda_sel <= sel_nx;
      bus.sda_ctl <= ctl_nx;
      bus.scl     <= scl_nx;
      bus.busy    <= busy_nx;
      bus.done    <= done_nx;
      bus.ack_err <= ack_err_nx;
    end
  end
endmodule
